// File: rtl/op_handler_dispatcher.sv
// One-op-in-flight dispatcher from op decode to NUM_HANDLERS handlers via a per-handler cmd mask.
// Optional WAIT watchdog enabled by defining OP_HANDLER_DISPATCHER_TIMEOUT_EN.
module op_handler_dispatcher #(
  parameter int unsigned NUM_HANDLERS   = 3,
  parameter int unsigned CMD_WIDTH      = 4,
  parameter int unsigned DATA_WIDTH     = 80,
  parameter int unsigned DEFAULT_CH     = NUM_HANDLERS - 1,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  localparam int unsigned NUM_CMDS      = 2 ** CMD_WIDTH,
  localparam int unsigned CH_WIDTH      = $clog2(NUM_HANDLERS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_trigger,
  input  logic [CMD_WIDTH-1:0]             in_cmd,
  input  logic [DATA_WIDTH-1:0]            in_data,
  output logic                             in_ready,
  output logic                             in_done,
  input  logic [NUM_HANDLERS*NUM_CMDS-1:0] cmd_mask,
  output logic [NUM_HANDLERS-1:0]          out_trigger,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CMD_WIDTH-1:0]             out_cmd,
  input  logic [NUM_HANDLERS-1:0]          handler_done,
  output logic [CH_WIDTH-1:0]              active_ch,
  output logic                             overrun,
  output logic                             stray_done,
`ifdef OP_HANDLER_DISPATCHER_TIMEOUT_EN
  output logic                             timeout,
`endif
  input  logic                             error_clr
);

  if (NUM_HANDLERS < 2 || NUM_HANDLERS > 8 || DEFAULT_CH >= NUM_HANDLERS ||
      TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("op_handler_dispatcher: illegal parameter combination");
  end

  typedef enum logic [1:0] {StIdle, StDispatch, StWait, StDone} state_e;

  state_e                  state_q, state_d;
  logic [CMD_WIDTH-1:0]    cmd_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [CH_WIDTH-1:0]     active_ch_q;
  logic                    overrun_q, overrun_d;
  logic                    stray_q, stray_d;

  logic [NUM_HANDLERS-1:0] hit;
  logic [CH_WIDTH-1:0]     sel_ch;
  logic [NUM_HANDLERS-1:0] ch_onehot;
  logic                    accept;
  logic                    done_match;
  logic                    done_other;
  logic                    timeout_hit;

  // Per-handler acceptance of the incoming command; mask is only consulted here.
  for (genvar h = 0; h < NUM_HANDLERS; h++) begin : g_hit
    logic [NUM_CMDS-1:0] mask_row;
    assign mask_row = cmd_mask[h*NUM_CMDS +: NUM_CMDS];
    assign hit[h]   = mask_row[in_cmd];
  end

  always_comb begin
    sel_ch = CH_WIDTH'(DEFAULT_CH);
    for (int i = int'(NUM_HANDLERS) - 1; i >= 0; i--) begin
      if (hit[i]) sel_ch = CH_WIDTH'(i);
    end
  end

  assign accept     = (state_q == StIdle) && in_trigger;
  assign ch_onehot  = NUM_HANDLERS'(1) << active_ch_q;
  assign done_match = (state_q == StWait) && |(handler_done & ch_onehot);
  // Outside WAIT every done is unexpected, including the selected handler's.
  assign done_other = (state_q == StWait) ? |(handler_done & ~ch_onehot) : |handler_done;

`ifdef OP_HANDLER_DISPATCHER_TIMEOUT_EN
  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
  logic                 timeout_q, timeout_d;

  assign timeout_hit = (state_q == StWait) && !done_match &&
                       (wait_cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == StDispatch) begin
      wait_cnt_d = '0;
    end else if (state_q == StWait) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    timeout_d = (timeout_q & ~error_clr) | timeout_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (in_trigger) state_d = StDispatch;
      StDispatch: state_d = StWait;
      StWait:     if (done_match || timeout_hit) state_d = StDone;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Outputs decoded from the registered state only
  always_comb begin
    in_ready    = (state_q == StIdle);
    in_done     = (state_q == StDone);
    out_trigger = (state_q == StDispatch) ? ch_onehot : '0;
  end

  // Sticky flags: a new violation wins over a same-cycle clear.
  always_comb begin
    overrun_d = (overrun_q & ~error_clr) | (in_trigger && (state_q != StIdle));
    stray_d   = (stray_q & ~error_clr) | done_other;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q       <= '0;
      data_q      <= '0;
      active_ch_q <= '0;
      overrun_q   <= 1'b0;
      stray_q     <= 1'b0;
    end else begin
      if (accept) begin
        cmd_q       <= in_cmd;
        data_q      <= in_data;
        active_ch_q <= sel_ch;
      end
      overrun_q <= overrun_d;
      stray_q   <= stray_d;
    end
  end

  assign out_cmd    = cmd_q;
  assign out_data   = data_q;
  assign active_ch  = active_ch_q;
  assign overrun    = overrun_q;
  assign stray_done = stray_q;

endmodule

// File: tb/tb_op_handler_dispatcher.sv
// Directed self-checking bench for op_handler_dispatcher (3 handlers, 4-bit cmd, 80-bit data).
// Timeout scenario runs only when OP_HANDLER_DISPATCHER_TIMEOUT_EN is defined.
module tb_op_handler_dispatcher;

  localparam int unsigned NH = 3;
  localparam int unsigned CW = 4;
  localparam int unsigned DW = 80;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_trigger;
  logic [CW-1:0]  in_cmd;
  logic [DW-1:0]  in_data;
  logic           in_ready;
  logic           in_done;
  logic [NH*16-1:0] cmd_mask;
  logic [NH-1:0]  out_trigger;
  logic [DW-1:0]  out_data;
  logic [CW-1:0]  out_cmd;
  logic [NH-1:0]  handler_done;
  logic [1:0]     active_ch;
  logic           overrun;
  logic           stray_done;
  logic           error_clr;
`ifdef OP_HANDLER_DISPATCHER_TIMEOUT_EN
  logic           timeout;
`endif

  int checks = 0;
  int errors = 0;

  op_handler_dispatcher #(
    .NUM_HANDLERS  (NH),
    .CMD_WIDTH     (CW),
    .DATA_WIDTH    (DW),
    .DEFAULT_CH    (2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_trigger  (in_trigger),
    .in_cmd      (in_cmd),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .in_done     (in_done),
    .cmd_mask    (cmd_mask),
    .out_trigger (out_trigger),
    .out_data    (out_data),
    .out_cmd     (out_cmd),
    .handler_done(handler_done),
    .active_ch   (active_ch),
    .overrun     (overrun),
    .stray_done  (stray_done),
`ifdef OP_HANDLER_DISPATCHER_TIMEOUT_EN
    .timeout     (timeout),
`endif
    .error_clr   (error_clr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // h0 = {0,1}, h1 = {2,3}, h2 = none
  localparam logic [47:0] MaskBase = 48'h0000_000C_0003;
  // h1 additionally accepts cmd 1
  localparam logic [47:0] MaskOvl  = 48'h0000_000E_0003;

  initial begin
    reset        = 1'b1;
    in_trigger   = 1'b0;
    in_cmd       = '0;
    in_data      = '0;
    cmd_mask     = MaskBase;
    handler_done = '0;
    error_clr    = 1'b0;
    tick();
    tick();
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_in_done", in_done, 0);
    check_eq("rst_out_trigger", out_trigger, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_active_ch", active_ch, 0);
    check_eq("rst_flags", {overrun, stray_done}, 0);
    reset = 1'b0;
    tick();

    // Op to handler 1
    in_trigger = 1'b1; in_cmd = 4'd2; in_data = 80'h1234;
    tick();
    in_trigger = 1'b0;
    check_eq("op1_trigger", out_trigger, 3'b010);
    check_eq("op1_data", out_data, 80'h1234);
    check_eq("op1_cmd", out_cmd, 4'd2);
    check_eq("op1_ch", active_ch, 1);
    check_eq("op1_busy", in_ready, 0);
    tick();
    check_eq("op1_trig_pulse", out_trigger, 0);
    handler_done = 3'b010;
    tick();
    handler_done = '0;
    check_eq("op1_done", in_done, 1);
    tick();
    check_eq("op1_done_pulse", in_done, 0);
    check_eq("op1_ready", in_ready, 1);
    check_eq("op1_no_stray", stray_done, 0);

    // No mask match -> default channel
    in_trigger = 1'b1; in_cmd = 4'd9; in_data = 80'h9999;
    tick();
    in_trigger = 1'b0;
    check_eq("dflt_trigger", out_trigger, 3'b100);
    check_eq("dflt_ch", active_ch, 2);
    tick();
    handler_done = 3'b100;
    tick();
    handler_done = '0;
    check_eq("dflt_done", in_done, 1);
    tick();

    // Overlapping masks: lowest handler wins
    cmd_mask = MaskOvl;
    in_trigger = 1'b1; in_cmd = 4'd1; in_data = 80'h5555;
    tick();
    in_trigger = 1'b0;
    cmd_mask = MaskBase;
    check_eq("prio_trigger", out_trigger, 3'b001);
    tick();

    // Overrun and stray during WAIT on ch0
    in_trigger = 1'b1; in_cmd = 4'd3; in_data = 80'hBEEF;
    tick();
    in_trigger = 1'b0;
    check_eq("ovr_flag", overrun, 1);
    check_eq("ovr_no_trigger", out_trigger, 0);
    check_eq("ovr_data_kept", out_data, 80'h5555);
    check_eq("ovr_cmd_kept", out_cmd, 4'd1);
    handler_done = 3'b100;
    tick();
    handler_done = '0;
    check_eq("stray_flag", stray_done, 1);
    check_eq("stray_still_wait", {in_ready, in_done}, 2'b00);
    error_clr = 1'b1;
    tick();
    error_clr = 1'b0;
    check_eq("clr_flags", {overrun, stray_done}, 0);
    handler_done = 3'b001;
    tick();
    handler_done = '0;
    check_eq("ch0_done", in_done, 1);
    tick();

    // Set wins over simultaneous clear
    handler_done = 3'b001; error_clr = 1'b1;
    tick();
    handler_done = '0; error_clr = 1'b0;
    check_eq("set_wins", stray_done, 1);
    check_eq("idle_done_ignored", in_done, 0);
    error_clr = 1'b1;
    tick();
    error_clr = 1'b0;
    check_eq("set_wins_clr", stray_done, 0);

    // Reset in WAIT abandons the op
    in_trigger = 1'b1; in_cmd = 4'd0; in_data = 80'hAAAA;
    tick();
    in_trigger = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check_eq("mid_rst_ready", in_ready, 1);
    check_eq("mid_rst_data", out_data, 0);
    check_eq("mid_rst_cmd_ch", {out_cmd, active_ch}, 0);
    check_eq("mid_rst_trig_done", {out_trigger, in_done}, 0);
    tick();
    reset = 1'b0;
    tick();
    handler_done = 3'b001;
    tick();
    handler_done = '0;
    check_eq("post_rst_stray", stray_done, 1);
    check_eq("post_rst_no_done", in_done, 0);
    tick();
    check_eq("post_rst_no_done2", in_done, 0);
    error_clr = 1'b1;
    tick();
    error_clr = 1'b0;

    // Back-to-back minimum turnaround
    in_trigger = 1'b1; in_cmd = 4'd0; in_data = 80'h0101;
    tick();
    in_trigger = 1'b0;
    check_eq("b2b_trigger", out_trigger, 3'b001);
    tick();
    handler_done = 3'b001;
    tick();
    handler_done = '0;
    check_eq("b2b_done_t3", in_done, 1);
    tick();
    check_eq("b2b_ready", in_ready, 1);
    in_trigger = 1'b1; in_cmd = 4'd3; in_data = 80'h0202;
    tick();
    in_trigger = 1'b0;
    check_eq("b2b_second_trigger", out_trigger, 3'b010);
    check_eq("b2b_second_data", out_data, 80'h0202);
    check_eq("b2b_no_overrun", overrun, 0);
    tick();
    handler_done = 3'b010;
    tick();
    handler_done = '0;
    check_eq("b2b_second_done", in_done, 1);
    tick();

`ifdef OP_HANDLER_DISPATCHER_TIMEOUT_EN
    // Watchdog: no done for 16 WAIT cycles
    in_trigger = 1'b1; in_cmd = 4'd2; in_data = 80'h7777;
    tick();
    in_trigger = 1'b0;
    tick();
    for (int k = 1; k < 16; k++) begin
      tick();
      check_eq("to_not_yet", {timeout, in_done}, 2'b00);
    end
    tick();
    check_eq("to_flag", timeout, 1);
    check_eq("to_done", in_done, 1);
    tick();
    check_eq("to_idle", in_ready, 1);
    error_clr = 1'b1;
    tick();
    error_clr = 1'b0;
    check_eq("to_clr", timeout, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
